// File: rtl/untransformer.sv
// untransformer: re-aligns diagonally skewed lane streams coming out of the
// systolic array. Lane k of a vector arrives k cycles after lane 0; each lane
// is delayed by size-1-k cycles so all lanes line up, then the vector is
// emitted as one registered word together with a valid strobe.
module untransformer #(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [data_size*size-1:0] skewed_data,
  output logic                      out_valid,
  output logic [data_size*size-1:0] aligned_data,
  output logic                      busy,
  output logic [31:0]               vector_count
);

  localparam int width = data_size * size;

  // All lanes of the vector whose valid bit sits in the last valid stage.
  logic [width-1:0] assembled;
  // Valid bit that accompanies 'assembled'.
  logic             last_valid;

  if (size == 1) begin : g_single
    // A single lane needs no alignment: the input word is the vector.
    assign assembled  = skewed_data;
    assign last_valid = in_valid;
    assign busy       = 1'b0;
  end else begin : g_skew
    logic [size-2:0] valid_pipe;

    // Valid tracking: stage 0 captures in_valid, later stages follow it.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_pipe <= '0;
      end else begin
        // NOTE: non-blocking assignments make every stage read the value
        // from before this edge, so the loop order does not matter.
        valid_pipe[0] <= in_valid;
        for (int i = 1; i < size - 1; i++) begin
          valid_pipe[i] <= valid_pipe[i-1];
        end
      end
    end

    assign last_valid = valid_pipe[size-2];
    assign busy       = |valid_pipe;

    for (genvar k = 0; k < size; k++) begin : g_lane
      localparam int depth = size - 1 - k;

      if (depth == 0) begin : g_direct
        // The last lane arrives exactly when the vector is complete.
        assign assembled[data_size*(size-k)-1 -: data_size] =
          skewed_data[data_size*(size-k)-1 -: data_size];
      end else begin : g_delay
        logic [data_size-1:0] delay_line [depth];

        // Per-lane delay line: holds lane k until the later lanes catch up.
        always_ff @(posedge clk) begin
          if (reset) begin
            // NOTE: these are a handful of flops, not a RAM, so clearing
            // them on reset is cheap and keeps discarded vectors out of view.
            for (int i = 0; i < depth; i++) begin
              delay_line[i] <= '0;
            end
          end else begin
            delay_line[0] <= skewed_data[data_size*(size-k)-1 -: data_size];
            for (int i = 1; i < depth; i++) begin
              delay_line[i] <= delay_line[i-1];
            end
          end
        end

        assign assembled[data_size*(size-k)-1 -: data_size] = delay_line[depth-1];
      end
    end
  end

  // Output register: emit the aligned vector, zero when idle, count emissions.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      aligned_data <= '0;
      vector_count <= '0;
    end else begin
      out_valid    <= last_valid;
      aligned_data <= last_valid ? assembled : '0;
      if (last_valid) begin
        vector_count <= vector_count + 32'd1;
      end
    end
  end

endmodule
